// File: rtl/controller_tx_pkg.sv
// Shared opcode constants and FSM state encoding for the controller transmit generator.
package controller_tx_pkg;

   localparam logic [2:0] OpStart   = 3'b000;
   localparam logic [2:0] OpData    = 3'b001;
   localparam logic [2:0] OpParity  = 3'b011;
   localparam logic [2:0] OpStop    = 3'b010;
   localparam logic [2:0] OpAck     = 3'b111;
   localparam logic [2:0] OpNack    = 3'b101;
   localparam logic [2:0] OpRstart  = 3'b110;
   localparam logic [2:0] OpHoldLow = 3'b100;

   typedef enum logic [3:0] {
      StIdle,
      StStart,
      StRstart,
      StRstartArm,
      StData,
      StParity,
      StTail,
      StAck,
      StNack,
      StStop
   } tx_state_e;

endpackage

// File: rtl/tx_shift_unit.sv
// Holds the latched command word, MSB-first bit index, current bit select and parity bit.
module tx_shift_unit #(
   parameter int unsigned DATA_W = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_load,
   input  logic                      i_dec,
   input  logic [DATA_W-1:0]         i_data,
   input  logic                      i_par_odd,
   output logic                      o_bit,
   output logic                      o_parity,
   output logic [$clog2(DATA_W)-1:0] o_bit_idx
);

   localparam int unsigned IdxW = $clog2(DATA_W);
   localparam logic [IdxW-1:0] IdxTop = IdxW'(DATA_W - 1);

   logic [DATA_W-1:0] r_word;
   logic              r_par_odd;
   logic [IdxW-1:0]   r_idx;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_word    <= '0;
         r_par_odd <= 1'b0;
         r_idx     <= IdxTop;
      end else if (i_load) begin
         r_word    <= i_data;
         r_par_odd <= i_par_odd;
         r_idx     <= IdxTop;
      end else if (i_dec && (r_idx != '0)) begin
         r_idx <= r_idx - 1'b1;
      end
   end

   assign o_bit     = r_word[r_idx];
   assign o_parity  = r_par_odd ? ~(^r_word) : (^r_word);
   assign o_bit_idx = r_idx;

endmodule

// File: rtl/controller_tx_gen.sv
// Transmit-side phase generator: accepts one opcode at a time and sequences SDA against SCL.
module controller_tx_gen #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_scl,
   input  logic                      i_scl_pos_edge,
   input  logic                      i_scl_neg_edge,
   input  logic                      i_cmd_valid,
   input  logic [2:0]                i_cmd,
   output logic                      o_cmd_ready,
   input  logic [DATA_W-1:0]         i_data,
   input  logic                      i_par_odd,
   input  logic                      i_timer_cas,
   input  logic                      i_timer_bus_free,
   output logic                      o_sda,
   output logic                      o_sda_drive_low,
   output logic                      o_start_pattern,
   output logic                      o_stop_pattern,
   output logic                      o_done,
   output logic                      o_pp_done,
   output logic                      o_busy,
   output logic [$clog2(DATA_W)-1:0] o_bit_idx
);

   import controller_tx_pkg::*;

   tx_state_e r_state, w_state_d;
   logic      r_sda, w_sda_d;
   logic      r_done, w_done_d;
   logic      r_pp_done, w_pp_done_d;
   logic      r_start_pat, w_start_d;
   logic      r_stop_pat, w_stop_d;
   logic      w_load, w_dec, w_bit, w_parity;

   tx_shift_unit #(
      .DATA_W (DATA_W)
   ) u_shift (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (w_load),
      .i_dec     (w_dec),
      .i_data    (i_data),
      .i_par_odd (i_par_odd),
      .o_bit     (w_bit),
      .o_parity  (w_parity),
      .o_bit_idx (o_bit_idx)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_sda       <= 1'b1;
         r_done      <= 1'b0;
         r_pp_done   <= 1'b0;
         r_start_pat <= 1'b0;
         r_stop_pat  <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_sda       <= w_sda_d;
         r_done      <= w_done_d;
         r_pp_done   <= w_pp_done_d;
         r_start_pat <= w_start_d;
         r_stop_pat  <= w_stop_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_sda_d     = r_sda;
      w_done_d    = 1'b0;
      w_pp_done_d = 1'b0;
      w_start_d   = r_start_pat;
      w_stop_d    = r_stop_pat;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_cmd_valid) begin
               w_load = 1'b1;
               // Single-cycle phases complete straight from IDLE so o_done lands in the entry cycle
               case (i_cmd)
                  OpStart:   w_state_d = StStart;
                  OpData:    w_state_d = StData;
                  OpRstart:  w_state_d = StRstart;
                  OpParity: begin
                     if (PARITY_EN) w_state_d = StParity;
                     else           w_done_d  = 1'b1;
                  end
                  OpStop: begin
                     w_state_d = StStop;
                     w_stop_d  = 1'b1;
                  end
                  OpAck: begin
                     w_state_d = StAck;
                     w_sda_d   = 1'b0;
                  end
                  OpNack: begin
                     w_state_d = StNack;
                     w_sda_d   = 1'b1;
                  end
                  OpHoldLow: begin
                     w_sda_d  = 1'b0;
                     w_done_d = 1'b1;
                  end
                  default: w_state_d = StIdle;
               endcase
            end
         end
         StStart: begin
            if (r_start_pat && i_timer_cas) begin
               w_start_d = 1'b0;
               w_done_d  = 1'b1;
               w_state_d = StIdle;
            end else if (i_scl) begin
               w_sda_d   = 1'b0;
               w_start_d = 1'b1;
            end else if (!r_start_pat) begin
               w_sda_d = 1'b1;
            end
         end
         StRstart: begin
            if (i_scl_pos_edge) w_state_d = StRstartArm;
            else if (!i_scl)    w_sda_d   = 1'b1;
         end
         StRstartArm: begin
            w_sda_d   = 1'b0;
            w_done_d  = 1'b1;
            w_state_d = StIdle;
         end
         StData: begin
            if (i_scl_pos_edge) begin
               if (o_bit_idx != '0) begin
                  w_dec = 1'b1;
               end else begin
                  w_pp_done_d = 1'b1;
                  w_state_d   = StTail;
               end
            end else if (!i_scl || i_scl_neg_edge) begin
               w_sda_d = w_bit;
            end
         end
         StParity: begin
            if (i_scl_pos_edge) begin
               w_pp_done_d = 1'b1;
               w_state_d   = StTail;
            end else if (!i_scl || i_scl_neg_edge) begin
               w_sda_d = w_parity;
            end
         end
         // Push-pull bit already sampled; hold SDA until SCL falls again
         StTail: begin
            if (i_scl_neg_edge && !i_scl_pos_edge) begin
               w_done_d  = 1'b1;
               w_state_d = StIdle;
            end
         end
         StAck, StNack: begin
            if (i_scl_pos_edge) begin
               w_done_d  = 1'b1;
               w_state_d = StIdle;
            end
         end
         StStop: begin
            if (i_timer_bus_free) begin
               w_stop_d  = 1'b0;
               w_done_d  = 1'b1;
               w_state_d = StIdle;
            end else begin
               w_sda_d = i_scl;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign o_cmd_ready     = (r_state == StIdle);
   assign o_busy          = (r_state != StIdle);
   assign o_sda_drive_low = (r_state == StAck);
   assign o_sda           = r_sda;
   assign o_done          = r_done;
   assign o_pp_done       = r_pp_done;
   assign o_start_pattern = r_start_pat;
   assign o_stop_pattern  = r_stop_pat;

endmodule

// File: tb/tb_controller_tx_gen.sv
// Directed bench: DATA/PARITY vector table plus hand sequences for START, RSTART, ACK/NACK, STOP, resets.
module tb_controller_tx_gen;

   localparam logic [2:0] OP_START  = 3'b000;
   localparam logic [2:0] OP_DATA   = 3'b001;
   localparam logic [2:0] OP_PARITY = 3'b011;
   localparam logic [2:0] OP_STOP   = 3'b010;
   localparam logic [2:0] OP_ACK    = 3'b111;
   localparam logic [2:0] OP_NACK   = 3'b101;
   localparam logic [2:0] OP_RSTART = 3'b110;
   localparam logic [2:0] OP_HOLD   = 3'b100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, scl, pos, neg, va, vb, vc, par_odd, cas, bfree;
   logic [2:0]  cmd;
   logic [11:0] data;

   logic a_ready, a_sda, a_dl, a_sp, a_tp, a_done, a_pp, a_busy;
   logic b_ready, b_sda, b_dl, b_sp, b_tp, b_done, b_pp, b_busy;
   logic c_ready, c_sda, c_dl, c_sp, c_tp, c_done, c_pp, c_busy;
   logic [2:0] a_idx, c_idx;
   logic [3:0] b_idx;

   controller_tx_gen #(.DATA_W(8), .PARITY_EN(1'b1)) u_a (
      .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_scl_pos_edge(pos), .i_scl_neg_edge(neg),
      .i_cmd_valid(va), .i_cmd(cmd), .o_cmd_ready(a_ready), .i_data(data[7:0]),
      .i_par_odd(par_odd), .i_timer_cas(cas), .i_timer_bus_free(bfree), .o_sda(a_sda),
      .o_sda_drive_low(a_dl), .o_start_pattern(a_sp), .o_stop_pattern(a_tp), .o_done(a_done),
      .o_pp_done(a_pp), .o_busy(a_busy), .o_bit_idx(a_idx));

   controller_tx_gen #(.DATA_W(12), .PARITY_EN(1'b1)) u_b (
      .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_scl_pos_edge(pos), .i_scl_neg_edge(neg),
      .i_cmd_valid(vb), .i_cmd(cmd), .o_cmd_ready(b_ready), .i_data(data),
      .i_par_odd(par_odd), .i_timer_cas(cas), .i_timer_bus_free(bfree), .o_sda(b_sda),
      .o_sda_drive_low(b_dl), .o_start_pattern(b_sp), .o_stop_pattern(b_tp), .o_done(b_done),
      .o_pp_done(b_pp), .o_busy(b_busy), .o_bit_idx(b_idx));

   controller_tx_gen #(.DATA_W(8), .PARITY_EN(1'b0)) u_c (
      .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_scl_pos_edge(pos), .i_scl_neg_edge(neg),
      .i_cmd_valid(vc), .i_cmd(cmd), .o_cmd_ready(c_ready), .i_data(data[7:0]),
      .i_par_odd(par_odd), .i_timer_cas(cas), .i_timer_bus_free(bfree), .o_sda(c_sda),
      .o_sda_drive_low(c_dl), .o_start_pattern(c_sp), .o_stop_pattern(c_tp), .o_done(c_done),
      .o_pp_done(c_pp), .o_busy(c_busy), .o_bit_idx(c_idx));

   // Output view of whichever 8- or 12-bit instance the current vector targets
   logic       msel;
   logic       m_sda, m_done, m_pp, m_busy, m_ready;
   logic [3:0] m_idx;
   assign m_sda   = msel ? b_sda   : a_sda;
   assign m_done  = msel ? b_done  : a_done;
   assign m_pp    = msel ? b_pp    : a_pp;
   assign m_busy  = msel ? b_busy  : a_busy;
   assign m_ready = msel ? b_ready : a_ready;
   assign m_idx   = msel ? b_idx   : {1'b0, a_idx};

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rise();
      scl = 1'b1; pos = 1'b1;
      tick();
      pos = 1'b0;
   endtask

   task automatic fall();
      scl = 1'b0; neg = 1'b1;
      tick();
      neg = 1'b0;
   endtask

   task automatic issue(input int sel, input logic [2:0] op);
      va = (sel == 0); vb = (sel == 1); vc = (sel == 2);
      cmd = op;
      tick();
      va = 1'b0; vb = 1'b0; vc = 1'b0;
   endtask

   typedef struct {
      int          sel;
      logic [11:0] word;
      logic        odd;
      int          nbits;
      logic [11:0] exp_seq;
      logic        exp_par;
   } vec_t;

   vec_t vecs[5];
   int   cnt, bad, seen;

   initial begin
      vecs[0] = '{sel: 0, word: 12'h0A5, odd: 1'b1, nbits: 8,  exp_seq: 12'b0000_1010_0101, exp_par: 1'b1};
      vecs[1] = '{sel: 1, word: 12'h801, odd: 1'b0, nbits: 12, exp_seq: 12'b1000_0000_0001, exp_par: 1'b0};
      vecs[2] = '{sel: 0, word: 12'h007, odd: 1'b1, nbits: 8,  exp_seq: 12'b0000_0000_0111, exp_par: 1'b0};
      vecs[3] = '{sel: 0, word: 12'h03C, odd: 1'b0, nbits: 8,  exp_seq: 12'b0000_0011_1100, exp_par: 1'b0};
      vecs[4] = '{sel: 1, word: 12'h5A3, odd: 1'b1, nbits: 12, exp_seq: 12'b0101_1010_0011, exp_par: 1'b1};

      rst = 1'b1; scl = 1'b0; pos = 1'b0; neg = 1'b0; va = 1'b0; vb = 1'b0; vc = 1'b0;
      cmd = 3'b000; data = '0; par_odd = 1'b0; cas = 1'b0; bfree = 1'b0; msel = 1'b0;
      tick(); tick();
      chk("rst_sda", a_sda, 1); chk("rst_ready", a_ready, 1); chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0); chk("rst_pp", a_pp, 0); chk("rst_start_pat", a_sp, 0);
      chk("rst_stop_pat", a_tp, 0); chk("rst_drive_low", a_dl, 0);
      chk("rst_idx8", a_idx, 7); chk("rst_idx12", b_idx, 11);
      rst = 1'b0;
      tick();

      // Timer strobes while idle
      cas = 1'b1; bfree = 1'b1;
      tick();
      cas = 1'b0; bfree = 1'b0;
      chk("idle_timer_start_pat", a_sp, 0); chk("idle_timer_stop_pat", a_tp, 0);
      chk("idle_timer_done", a_done, 0);

      // START with SCL high, CAS expiry 5 cycles after entry
      scl = 1'b1;
      issue(0, OP_START);
      chk("start_busy", a_busy, 1);
      cnt = 0;
      repeat (5) begin
         tick();
         cnt += int'(a_sp);
      end
      chk("start_sda_low", a_sda, 0);
      cas = 1'b1;
      tick();
      cas = 1'b0;
      chk("start_pat_cycles", cnt, 5); chk("start_pat_drop", a_sp, 0);
      chk("start_done", a_done, 1); chk("start_ready", a_ready, 1);
      tick();
      chk("start_done_pulse", a_done, 0);

      // RSTART: SDA high while SCL low, arm on posedge, fall the cycle after
      fall();
      issue(0, OP_RSTART);
      tick();
      chk("rstart_sda_high", a_sda, 1); chk("rstart_no_done", a_done, 0);
      rise();
      chk("rstart_arm_no_done", a_done, 0);
      tick();
      chk("rstart_sda_low", a_sda, 0); chk("rstart_done", a_done, 1);

      // ACK then STOP
      fall();
      issue(0, OP_ACK);
      chk("ack_drive_low", a_dl, 1); chk("ack_sda", a_sda, 0);
      tick();
      chk("ack_drive_low_hold", a_dl, 1);
      rise();
      chk("ack_release", a_dl, 0); chk("ack_done", a_done, 1);

      fall();
      issue(0, OP_NACK);
      chk("nack_sda", a_sda, 1);
      tick();
      chk("nack_no_done", a_done, 0);
      rise();
      chk("nack_done", a_done, 1);

      fall();
      issue(0, OP_STOP);
      cnt = int'(a_tp);
      bad = 0;
      for (int j = 1; j <= 9; j++) begin
         if (j == 3) begin scl = 1'b1; pos = 1'b1; end
         tick();
         pos = 1'b0;
         cnt += int'(a_tp);
         if (a_sda && !scl) bad++;
         if (j == 1) chk("stop_sda_low", a_sda, 0);
      end
      chk("stop_sda_rise_scl_high", bad, 0);
      bfree = 1'b1;
      tick();
      bfree = 1'b0;
      chk("stop_pat_cycles", cnt, 10); chk("stop_pat_drop", a_tp, 0);
      chk("stop_done", a_done, 1); chk("stop_sda_high", a_sda, 1);

      // DATA vectors, each followed back-to-back by PARITY in the o_done cycle
      scl = 1'b0;
      tick();
      for (int v = 0; v < 5; v++) begin
         msel = vecs[v].sel[0];
         data = vecs[v].word;
         par_odd = vecs[v].odd;
         issue(vecs[v].sel, OP_DATA);
         chk("data_busy", m_busy, 1);
         chk("data_idx_load", m_idx, vecs[v].nbits - 1);
         for (int k = 0; k < vecs[v].nbits; k++) begin
            tick();
            chk("data_bit", m_sda, vecs[v].exp_seq[vecs[v].nbits-1-k]);
            chk("data_idx", m_idx, vecs[v].nbits - 1 - k);
            rise();
            chk("data_pp", m_pp, (k == vecs[v].nbits - 1) ? 1 : 0);
            tick();
            chk("data_pp_pulse", m_pp, 0); chk("data_no_done", m_done, 0);
            fall();
         end
         chk("data_done", m_done, 1); chk("data_done_ready", m_ready, 1);
         issue(vecs[v].sel, OP_PARITY);
         chk("parity_no_idle", m_busy, 1);
         tick();
         chk("parity_bit", m_sda, vecs[v].exp_par);
         rise();
         chk("parity_pp", m_pp, 1);
         tick();
         chk("parity_no_done", m_done, 0);
         fall();
         chk("parity_done", m_done, 1);
         tick();
         chk("parity_done_pulse", m_done, 0);
      end
      msel = 1'b0;

      // PARITY with the phase disabled
      issue(2, OP_PARITY);
      chk("par_dis_done", c_done, 1); chk("par_dis_busy", c_busy, 0); chk("par_dis_sda", c_sda, 1);
      tick();
      chk("par_dis_done_pulse", c_done, 0);

      issue(0, OP_HOLD);
      chk("hold_done", a_done, 1); chk("hold_sda", a_sda, 0); chk("hold_busy", a_busy, 0);
      tick();
      chk("hold_sda_idle", a_sda, 0); chk("hold_done_pulse", a_done, 0);

      // Coincident SCL strobes advance the index once
      data = 12'h095;
      issue(0, OP_DATA);
      tick();
      chk("coinc_idx_before", a_idx, 7);
      scl = 1'b1; pos = 1'b1; neg = 1'b1;
      tick();
      pos = 1'b0; neg = 1'b0;
      chk("coinc_idx_once", a_idx, 6);
      tick();
      chk("coinc_idx_hold", a_idx, 6);
      fall();
      tick();
      chk("coinc_next_bit", a_sda, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Reset mid-DATA at bit 4 of 0xA5
      data = 12'h0A5; par_odd = 1'b1;
      issue(0, OP_DATA);
      tick();
      repeat (3) begin
         rise(); tick(); fall();
      end
      chk("abort_idx", a_idx, 4); chk("abort_bit4", a_sda, 0);
      #2 rst = 1'b1;
      #1;
      chk("abort_sda_async", a_sda, 1); chk("abort_busy", a_busy, 0);
      chk("abort_ready", a_ready, 1); chk("abort_idx_rst", a_idx, 7);
      tick();
      rst = 1'b0;
      seen = 0;
      repeat (3) begin
         rise(); seen += int'(a_done);
         fall(); seen += int'(a_done);
      end
      chk("abort_no_done", seen, 0);

      // Reset mid-STOP drops the pattern request
      issue(0, OP_STOP);
      chk("stop_abort_pat_before", a_tp, 1);
      #2 rst = 1'b1;
      #1;
      chk("stop_abort_pat", a_tp, 0); chk("stop_abort_sda", a_sda, 1);
      tick();
      rst = 1'b0;
      tick();
      chk("stop_abort_no_done", a_done, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
